stack_op_sequencer: RTL and testbench
=====================================

Name: stack_op_sequencer

Overview:
Command-level controller for the single-write-port, async-read LIFO stack block. It accepts one stack-machine opcode at a time over a valid/ready handshake and checks depth and free space up front. It then sequences the stack's push/pop/peek/poke strobes over several cycles and returns a one-cycle response with result and error code. It sits between an instruction decoder (e.g. a Forth/RPN core) and the stack instance.

Parameters:
WIDTH, 8, data word width (must match the stack instance)
DEPTH, 256, stack depth (must match the stack instance); IW = $clog2(DEPTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_op  in  4  opcode
cmd_imm  in  WIDTH  immediate for PUSH/POKE
cmd_index  in  IW  index for PEEK/POKE (0 = top)
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  WIDTH  result word
rsp_err  out  2  0 ok, 1 underflow, 2 overflow, 3 illegal opcode
busy  out  1  high in every state except IDLE
st_push_en, st_pop_en, st_peek_en, st_poke_en  out  1 each  stack strobes
st_data_in  out  WIDTH  stack write data
st_index  out  IW  stack index
st_data_out  in  WIDTH  stack read data (combinational)
st_full, st_empty  in  1 each  stack flags
st_depth  in  IW+1  stack occupancy

Behaviour:
- Opcodes: 0 NOP, 1 PUSH, 2 DROP, 3 DUP, 4 SWAP, 5 OVER, 6 ADD, 7 SUB, 8 AND, 9 OR, A XOR, B PEEK, C POKE; D–F illegal.
- Accept when cmd_valid && cmd_ready. Latch op/imm/index. Check against st_depth in the same cycle:
  - Need >=1 entry: DROP, DUP.
  - Need >=2 entries: SWAP, OVER, ADD..XOR.
  - Need cmd_index < st_depth: PEEK, POKE.
  - Failing any of these gives err=1.
  - PUSH/DUP/OVER with st_full gives err=2.
  - Illegal opcode gives err=3.
  - On error: go straight to DONE, assert no stack strobe, rsp_data=0.
- States: IDLE, LOAD_A, LOAD_B, POP, WR0, WR1, DONE. DONE always returns to IDLE.
- Paths from IDLE:
  - NOP: DONE.
  - PUSH: WR0 (push imm).
  - DROP: POP.
  - DUP: LOAD_A, WR0 (push a).
  - OVER: LOAD_B, WR0 (push b).
  - SWAP: LOAD_A, LOAD_B, WR0 (poke idx0 <- b), WR1 (poke idx1 <- a).
  - ALU ops: LOAD_A, LOAD_B, POP, WR0 (poke idx0 <- r).
  - PEEK: LOAD_A with st_index=cmd_index.
  - POKE: WR0 (poke cmd_index <- imm).
  - All paths end in DONE.
- State actions:
  - LOAD_A: peek_en=1, index 0 (cmd_index for PEEK); latch st_data_out into a.
  - LOAD_B: peek_en=1, index 1; latch into b.
  - POP: pop_en=1; latch st_data_out (current top) into p.
- At most one strobe is asserted per cycle; all strobes are 0 in IDLE and DONE. st_data_in and st_index are 0 when unused.
- ALU result r = b op a, where a is the top and b is second. SUB = b - a. Arithmetic is modulo 2^WIDTH with no carry out.
- The poke in WR0 after POP targets the new top, because depth has already decremented.
- rsp_data in DONE, by op:
  - PUSH, POKE: imm.
  - DROP: p.
  - DUP, PEEK: a.
  - OVER: b.
  - SWAP: b.
  - ALU: r.
  - NOP: 0.
- Latency from accept edge to rsp_valid high:
  - 1 cycle: NOP, errors.
  - 2 cycles: PUSH, DROP, POKE, PEEK.
  - 3 cycles: DUP, OVER.
  - 5 cycles: SWAP, ALU.
- Back-to-back: the earliest next accept is the cycle after DONE. cmd_valid is ignored while busy.
- Reset (any cycle, including mid-sequence):
  - State goes to IDLE.
  - a, b, p, r are cleared.
  - cmd_ready=1 in the cycle after reset deasserts.
  - rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, all strobes 0.
  - The stack is not rolled back. The integrator ties the stack's rst_n to !rst so both clear together.

Test Plan:
- Reset, then PUSH 0x11, PUSH 0x22, PUSH 0x33 -> each rsp_valid 2 cycles after accept, rsp_err=0, st_depth=3, rsp_data=0x33 on the last.
- From [0x11,0x22,0x33] (top 0x33): SWAP -> rsp_data=0x22; PEEK 0 =0x22, PEEK 1 =0x33; depth stays 3; rsp_valid 5 cycles after accept.
- Stack [0x05,0x03] (top 0x03): SUB -> rsp_data=0x02, depth 1. Then PUSH 0x04, SUB -> rsp_data=0xFE (wrap), depth 1.
- Empty stack: DROP -> rsp_err=1, 1-cycle latency, no strobe; PEEK index 0 -> err=1; opcode 0xE -> err=3.
- Full stack (DEPTH=4, four pushes): DUP -> err=2, depth stays 4; DROP -> rsp_data = last pushed value, depth 3.
- Assert rst during LOAD_B of an ADD -> next cycle cmd_ready=1, busy=0, no rsp_valid pulse; a following PUSH completes normally.

Source files
------------

// File: rtl/stack_op_sequencer_if.sv
// Command/response handshake between an instruction decoder and stack_op_sequencer.
// master = decoder side, slave = sequencer side.
interface stack_op_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int IW    = $clog2(DEPTH)
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_imm;
    logic [IW-1:0]    cmd_index;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic [1:0]       rsp_err;
    logic             busy;

    modport master (
        output cmd_valid, cmd_op, cmd_imm, cmd_index,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_imm, cmd_index,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/stack_op_sequencer.sv
// Sequences stack push/pop/peek/poke strobes for one stack-machine opcode at a time.
// Latency accept->rsp_valid: 1 (NOP/err), 2 (PUSH/DROP/PEEK/POKE), 3 (DUP/OVER), 5 (SWAP/ALU).
// Backpressure: cmd_ready only in IDLE; cmd_valid ignored while busy; response is a 1-cycle pulse.
module stack_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    stack_op_sequencer_if.slave cmd_if,
    output logic             st_push_en,
    output logic             st_pop_en,
    output logic             st_peek_en,
    output logic             st_poke_en,
    output logic [WIDTH-1:0] st_data_in,
    output logic [IW-1:0]    st_index,
    input  logic [WIDTH-1:0] st_data_out,
    input  logic             st_full,
    input  logic             st_empty,
    input  logic [IW:0]      st_depth
);
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_PUSH = 4'h1;
    localparam logic [3:0] OP_DROP = 4'h2;
    localparam logic [3:0] OP_DUP  = 4'h3;
    localparam logic [3:0] OP_SWAP = 4'h4;
    localparam logic [3:0] OP_OVER = 4'h5;
    localparam logic [3:0] OP_ADD  = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_PEEK = 4'hB;
    localparam logic [3:0] OP_POKE = 4'hC;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_UNDER = 2'd1;
    localparam logic [1:0] ERR_OVER  = 2'd2;
    localparam logic [1:0] ERR_ILL   = 2'd3;

    localparam logic [IW:0] TWO_ENTRIES = (IW+1)'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_POP,
        S_WR0,
        S_WR1,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [1:0]       err_q, err_d;
    logic [1:0]       chk_err;
    logic             op_is_alu;

    function automatic logic [WIDTH-1:0] alu(input logic [3:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] res;
        res = '0;
        case (op)
            OP_ADD:  res = b + a;
            OP_SUB:  res = b - a;
            OP_AND:  res = b & a;
            OP_OR:   res = b | a;
            OP_XOR:  res = b ^ a;
            default: res = '0;
        endcase
        return res;
    endfunction

    assign op_is_alu = (op_q >= OP_ADD) && (op_q <= OP_XOR);

    // Up-front depth/space check on the offered command, evaluated in the accept cycle.
    always_comb begin
        chk_err = ERR_OK;
        case (cmd_if.cmd_op)
            OP_NOP:  chk_err = ERR_OK;
            OP_PUSH: if (st_full) chk_err = ERR_OVER;
            OP_DROP: if (st_empty) chk_err = ERR_UNDER;
            OP_DUP: begin
                if (st_empty)     chk_err = ERR_UNDER;
                else if (st_full) chk_err = ERR_OVER;
            end
            OP_OVER: begin
                if (st_depth < TWO_ENTRIES) chk_err = ERR_UNDER;
                else if (st_full)           chk_err = ERR_OVER;
            end
            OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                if (st_depth < TWO_ENTRIES) chk_err = ERR_UNDER;
            end
            OP_PEEK, OP_POKE: begin
                if (!({1'b0, cmd_if.cmd_index} < st_depth)) chk_err = ERR_UNDER;
            end
            default: chk_err = ERR_ILL;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        imm_d      = imm_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        p_d        = p_q;
        r_d        = r_q;
        err_d      = err_q;
        st_push_en = 1'b0;
        st_pop_en  = 1'b0;
        st_peek_en = 1'b0;
        st_poke_en = 1'b0;
        st_data_in = '0;
        st_index   = '0;

        case (state_q)
            S_IDLE: begin
                if (cmd_if.cmd_valid) begin
                    op_d  = cmd_if.cmd_op;
                    imm_d = cmd_if.cmd_imm;
                    idx_d = cmd_if.cmd_index;
                    err_d = chk_err;
                    if (chk_err != ERR_OK) begin
                        state_d = S_DONE;
                    end else begin
                        case (cmd_if.cmd_op)
                            OP_PUSH, OP_POKE: state_d = S_WR0;
                            OP_DROP:          state_d = S_POP;
                            OP_OVER:          state_d = S_LOAD_B;
                            OP_DUP, OP_SWAP, OP_PEEK,
                            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                                              state_d = S_LOAD_A;
                            default:          state_d = S_DONE;
                        endcase
                    end
                end
            end
            S_LOAD_A: begin
                st_peek_en = 1'b1;
                st_index   = (op_q == OP_PEEK) ? idx_q : '0;
                a_d        = st_data_out;
                if (op_q == OP_PEEK)     state_d = S_DONE;
                else if (op_q == OP_DUP) state_d = S_WR0;
                else                     state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                st_peek_en = 1'b1;
                st_index   = IW'(1);
                b_d        = st_data_out;
                if (op_q == OP_OVER || op_q == OP_SWAP) state_d = S_WR0;
                else                                     state_d = S_POP;
            end
            S_POP: begin
                st_pop_en = 1'b1;
                p_d       = st_data_out;
                r_d       = alu(op_q, a_q, b_q);
                state_d   = op_is_alu ? S_WR0 : S_DONE;
            end
            S_WR0: begin
                // After the ALU pop, index 0 already addresses the new top.
                case (op_q)
                    OP_PUSH: begin st_push_en = 1'b1; st_data_in = imm_q; end
                    OP_DUP:  begin st_push_en = 1'b1; st_data_in = a_q;   end
                    OP_OVER: begin st_push_en = 1'b1; st_data_in = b_q;   end
                    OP_SWAP: begin st_poke_en = 1'b1; st_data_in = b_q;   end
                    OP_POKE: begin
                        st_poke_en = 1'b1;
                        st_data_in = imm_q;
                        st_index   = idx_q;
                    end
                    default: begin st_poke_en = 1'b1; st_data_in = r_q;   end
                endcase
                state_d = (op_q == OP_SWAP) ? S_WR1 : S_DONE;
            end
            S_WR1: begin
                st_poke_en = 1'b1;
                st_index   = IW'(1);
                st_data_in = a_q;
                state_d    = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_if.rsp_data = '0;
        if (state_q == S_DONE && err_q == ERR_OK) begin
            case (op_q)
                OP_PUSH, OP_POKE: cmd_if.rsp_data = imm_q;
                OP_DROP:          cmd_if.rsp_data = p_q;
                OP_DUP, OP_PEEK:  cmd_if.rsp_data = a_q;
                OP_OVER, OP_SWAP: cmd_if.rsp_data = b_q;
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                                  cmd_if.rsp_data = r_q;
                default:          cmd_if.rsp_data = '0;
            endcase
        end
    end

    assign cmd_if.cmd_ready = (state_q == S_IDLE);
    assign cmd_if.busy      = (state_q != S_IDLE);
    assign cmd_if.rsp_valid = (state_q == S_DONE);
    assign cmd_if.rsp_err   = (state_q == S_DONE) ? err_q : ERR_OK;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            imm_q   <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            r_q     <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            r_q     <= r_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_stack_op_sequencer.sv
// Scoreboarded bench for stack_op_sequencer driving a behavioural 4-deep LIFO.
module tb_stack_op_sequencer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int IW    = 2;

    localparam logic [3:0] NOP = 4'h0, PUSH = 4'h1, DROP = 4'h2, DUP = 4'h3,
                           SWAP = 4'h4, OVER = 4'h5, ADD = 4'h6, SUB = 4'h7,
                           AND_ = 4'h8, OR_ = 4'h9, XOR_ = 4'hA, PEEK = 4'hB,
                           POKE = 4'hC;

    logic clk = 1'b0;
    logic rst;
    logic             st_push_en, st_pop_en, st_peek_en, st_poke_en;
    logic [WIDTH-1:0] st_data_in, st_data_out;
    logic [IW-1:0]    st_index;
    logic             st_full, st_empty;
    logic [IW:0]      st_depth;

    stack_op_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) cmd_if ();

    stack_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_if(cmd_if),
        .st_push_en(st_push_en), .st_pop_en(st_pop_en),
        .st_peek_en(st_peek_en), .st_poke_en(st_poke_en),
        .st_data_in(st_data_in), .st_index(st_index),
        .st_data_out(st_data_out), .st_full(st_full),
        .st_empty(st_empty), .st_depth(st_depth)
    );

    always #5 clk = ~clk;

    // Behavioural LIFO: index 0 = top, async read, reset tied to the sequencer's.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW:0]      slot;
    assign slot        = st_depth - 3'd1 - {1'b0, st_index};
    assign st_data_out = (st_depth > {1'b0, st_index}) ? mem[slot[IW-1:0]] : '0;
    assign st_full     = (st_depth == 3'(DEPTH));
    assign st_empty    = (st_depth == '0);

    always @(posedge clk) begin
        if (rst) begin
            st_depth <= '0;
        end else begin
            if (st_push_en && !st_full) begin
                mem[st_depth[IW-1:0]] <= st_data_in;
                st_depth <= st_depth + 3'd1;
            end
            if (st_pop_en && !st_empty) st_depth <= st_depth - 3'd1;
            if (st_poke_en) mem[slot[IW-1:0]] <= st_data_in;
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stb_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        if (st_push_en || st_pop_en || st_peek_en || st_poke_en) stb_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [1:0]       err;
        int               lat;
        int               acc;
        string            name;
    } exp_t;
    exp_t sb_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            chk("strobe_onehot",
                int'($countones({st_push_en, st_pop_en, st_peek_en, st_poke_en}) <= 1), 1);
            if (cmd_if.rsp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk({e.name, "_data"}, int'(cmd_if.rsp_data), int'(e.data));
                    chk({e.name, "_err"}, int'(cmd_if.rsp_err), int'(e.err));
                    chk({e.name, "_lat"}, cyc - e.acc, e.lat);
                end
            end
        end
    end

    task automatic issue(input string name, input logic [3:0] op,
                         input logic [WIDTH-1:0] imm, input logic [IW-1:0] idx,
                         input logic [WIDTH-1:0] ed, input logic [1:0] ee,
                         input int el, input bit exp_en);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!cmd_if.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk({name, "_ready_timeout"}, 0, 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_imm   = imm;
        cmd_if.cmd_index = idx;
        if (exp_en) begin
            e.data = ed; e.err = ee; e.lat = el; e.acc = cyc; e.name = name;
            sb_q.push_back(e);
        end
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = '0;
        cmd_if.cmd_imm   = '0;
        cmd_if.cmd_index = '0;
        if (exp_en) begin
            n = 0;
            while (sb_q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) chk({name, "_rsp_timeout"}, 0, 1);
        end
    endtask

    task automatic do_ok(input string name, input logic [3:0] op,
                         input logic [WIDTH-1:0] imm, input logic [IW-1:0] idx,
                         input logic [WIDTH-1:0] ed, input int el);
        issue(name, op, imm, idx, ed, 2'd0, el, 1'b1);
    endtask

    task automatic do_err(input string name, input logic [3:0] op,
                          input logic [IW-1:0] idx, input logic [1:0] ee);
        int s0;
        s0 = stb_cnt;
        issue(name, op, 8'hA5, idx, 8'h00, ee, 1, 1'b1);
        chk({name, "_nostrobe"}, stb_cnt - s0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = '0;
        cmd_if.cmd_imm   = '0;
        cmd_if.cmd_index = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", int'(cmd_if.cmd_ready), 1);
        chk("rst_busy", int'(cmd_if.busy), 0);
        chk("rst_rsp_valid", int'(cmd_if.rsp_valid), 0);
        chk("rst_rsp_data", int'(cmd_if.rsp_data), 0);
        chk("rst_strobes", int'({st_push_en, st_pop_en, st_peek_en, st_poke_en}), 0);

        do_ok("push11", PUSH, 8'h11, 2'd0, 8'h11, 2);
        do_ok("push22", PUSH, 8'h22, 2'd0, 8'h22, 2);
        do_ok("push33", PUSH, 8'h33, 2'd0, 8'h33, 2);
        chk("depth_after_push", int'(st_depth), 3);

        do_ok("swap", SWAP, 8'h00, 2'd0, 8'h22, 5);
        do_ok("peek0", PEEK, 8'h00, 2'd0, 8'h22, 2);
        do_ok("peek1", PEEK, 8'h00, 2'd1, 8'h33, 2);
        chk("depth_after_swap", int'(st_depth), 3);

        do_ok("drop_a", DROP, 8'h00, 2'd0, 8'h22, 2);
        do_ok("drop_b", DROP, 8'h00, 2'd0, 8'h33, 2);
        do_ok("drop_c", DROP, 8'h00, 2'd0, 8'h11, 2);
        chk("depth_empty", int'(st_depth), 0);

        do_err("drop_empty", DROP, 2'd0, 2'd1);
        do_err("peek_empty", PEEK, 2'd0, 2'd1);
        do_err("illegal_e", 4'hE, 2'd0, 2'd3);
        issue("nop", NOP, 8'h5A, 2'd0, 8'h00, 2'd0, 1, 1'b1);

        do_ok("push05", PUSH, 8'h05, 2'd0, 8'h05, 2);
        do_ok("push03", PUSH, 8'h03, 2'd0, 8'h03, 2);
        do_ok("sub1", SUB, 8'h00, 2'd0, 8'h02, 5);
        chk("depth_sub1", int'(st_depth), 1);
        do_ok("push04", PUSH, 8'h04, 2'd0, 8'h04, 2);
        do_ok("sub_wrap", SUB, 8'h00, 2'd0, 8'hFE, 5);
        chk("depth_sub2", int'(st_depth), 1);

        do_ok("dup", DUP, 8'h00, 2'd0, 8'hFE, 3);
        do_ok("push0f", PUSH, 8'h0F, 2'd0, 8'h0F, 2);
        do_ok("over", OVER, 8'h00, 2'd0, 8'hFE, 3);
        chk("depth_full", int'(st_depth), 4);
        do_err("dup_full", DUP, 2'd0, 2'd2);
        do_err("push_full", PUSH, 2'd0, 2'd2);
        chk("depth_still_full", int'(st_depth), 4);
        do_ok("drop_full", DROP, 8'h00, 2'd0, 8'hFE, 2);
        chk("depth_3", int'(st_depth), 3);

        do_ok("xor", XOR_, 8'h00, 2'd0, 8'hF1, 5);
        do_ok("and", AND_, 8'h00, 2'd0, 8'hF0, 5);
        do_ok("poke0", POKE, 8'h3C, 2'd0, 8'h3C, 2);
        do_ok("peek_poked", PEEK, 8'h00, 2'd0, 8'h3C, 2);
        do_err("poke_oob", POKE, 2'd1, 2'd1);
        do_ok("pushc3", PUSH, 8'hC3, 2'd0, 8'hC3, 2);
        do_ok("or", OR_, 8'h00, 2'd0, 8'hFF, 5);
        do_ok("push02", PUSH, 8'h02, 2'd0, 8'h02, 2);
        do_ok("add_wrap", ADD, 8'h00, 2'd0, 8'h01, 5);
        chk("depth_1", int'(st_depth), 1);

        // Reset while the ADD sits in LOAD_B: no response may follow.
        do_ok("push10", PUSH, 8'h10, 2'd0, 8'h10, 2);
        issue("add_abort", ADD, 8'h00, 2'd0, 8'h00, 2'd0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", int'(cmd_if.cmd_ready), 1);
        chk("mid_rst_busy", int'(cmd_if.busy), 0);
        chk("mid_rst_rsp_valid", int'(cmd_if.rsp_valid), 0);
        chk("mid_rst_depth", int'(st_depth), 0);
        repeat (6) @(negedge clk);
        do_ok("push77", PUSH, 8'h77, 2'd0, 8'h77, 2);
        chk("depth_after_rst", int'(st_depth), 1);

        repeat (4) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
